// File: rtl/red_pitaya_pll_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module : red_pitaya_pll_rst_seq_if
// Brief  : PLL-facing and status signals of the PLL reset sequencer.
//          Macro PLL_RST_SEQ_LOSS_CNT_EN adds lock_loss_cnt_o.
// Rev    : 1.0
// ============================================================================
interface red_pitaya_pll_rst_seq_if;
   logic       pll_locked_i;
   logic       retry_i;
   logic       pll_rstn_o;
   logic       sys_rstn_o;
   logic [2:0] state_o;
   logic [7:0] retry_cnt_o;
   logic       fail_o;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   logic [15:0] lock_loss_cnt_o;

   modport slave  (input  pll_locked_i, retry_i,
                   output pll_rstn_o, sys_rstn_o, state_o, retry_cnt_o, fail_o, lock_loss_cnt_o);
   modport master (output pll_locked_i, retry_i,
                   input  pll_rstn_o, sys_rstn_o, state_o, retry_cnt_o, fail_o, lock_loss_cnt_o);
`else
   modport slave  (input  pll_locked_i, retry_i,
                   output pll_rstn_o, sys_rstn_o, state_o, retry_cnt_o, fail_o);
   modport master (output pll_locked_i, retry_i,
                   input  pll_rstn_o, sys_rstn_o, state_o, retry_cnt_o, fail_o);
`endif
endinterface
`default_nettype wire

// File: rtl/red_pitaya_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module : red_pitaya_pll_rst_seq
// Brief  : PLL reset / lock-qualification sequencer on the PLL reference clock.
//          Macro PLL_RST_SEQ_LOSS_CNT_EN enables the lock-loss counter.
// Rev    : 1.0
// ============================================================================
module red_pitaya_pll_rst_seq #(
   parameter int unsigned PLL_RST_CYC  = 16,
   parameter int unsigned LOCK_TMO_CYC = 65536,
   parameter int unsigned LOCK_STB_CYC = 1024,
   parameter int unsigned MAX_RETRY    = 4,
   parameter int unsigned CNT_W        = 17
) (
   input wire                       clk,
   input wire                       rstn,
   red_pitaya_pll_rst_seq_if.slave  pll_if
);

   localparam logic [2:0] c_st_pll_rst   = 3'd0;
   localparam logic [2:0] c_st_wait_lock = 3'd1;
   localparam logic [2:0] c_st_stable    = 3'd2;
   localparam logic [2:0] c_st_run       = 3'd3;
   localparam logic [2:0] c_st_fail      = 3'd4;

   localparam logic [CNT_W-1:0] c_rst_lim = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] c_tmo_lim = CNT_W'(LOCK_TMO_CYC - 1);
   localparam logic [CNT_W-1:0] c_stb_lim = CNT_W'(LOCK_STB_CYC - 1);

   logic             sync1_q, sync1_d;
   logic             lock_s_q, lock_s_d;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_cnt_q, retry_cnt_d;
   logic [7:0]       retry_inc;
   logic             pll_rstn_q, pll_rstn_d;
   logic             sys_rstn_q, sys_rstn_d;
   logic             fail_q, fail_d;

   always_comb begin
      sync1_d     = pll_if.pll_locked_i;
      lock_s_d    = sync1_q;
      retry_inc   = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
      state_d     = state_q;
      cnt_d       = cnt_q;
      retry_cnt_d = retry_cnt_q;

      if (pll_if.retry_i) begin
         state_d     = c_st_pll_rst;
         cnt_d       = '0;
         retry_cnt_d = '0;
      end else begin
         case (state_q)
            c_st_pll_rst: begin
               if (cnt_q >= c_rst_lim) begin
                  state_d = c_st_wait_lock;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            c_st_wait_lock: begin
               // Lock is tested first so a coincident timeout loses to it.
               if (lock_s_q) begin
                  state_d = c_st_stable;
                  cnt_d   = '0;
               end else if (cnt_q >= c_tmo_lim) begin
                  retry_cnt_d = retry_inc;
                  cnt_d       = '0;
                  state_d     = (MAX_RETRY != 0 && 32'(retry_inc) >= MAX_RETRY)
                                ? c_st_fail : c_st_pll_rst;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            c_st_stable: begin
               if (!lock_s_q) begin
                  state_d = c_st_wait_lock;
                  cnt_d   = '0;
               end else if (cnt_q >= c_stb_lim) begin
                  state_d     = c_st_run;
                  cnt_d       = '0;
                  retry_cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            c_st_run: begin
               if (!lock_s_q) begin
                  state_d     = c_st_pll_rst;
                  retry_cnt_d = retry_inc;
               end
            end
            c_st_fail: begin
               state_d = c_st_fail;
            end
            default: begin
               state_d = c_st_pll_rst;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they change with it.
      pll_rstn_d = (state_d == c_st_wait_lock) || (state_d == c_st_stable) ||
                   (state_d == c_st_run);
      sys_rstn_d = (state_d == c_st_run);
      fail_d     = (state_d == c_st_fail);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q     <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= c_st_pll_rst;
         cnt_q       <= '0;
         retry_cnt_q <= '0;
         pll_rstn_q  <= 1'b0;
         sys_rstn_q  <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         lock_s_q    <= lock_s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_cnt_q <= retry_cnt_d;
         pll_rstn_q  <= pll_rstn_d;
         sys_rstn_q  <= sys_rstn_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_if.pll_rstn_o  = pll_rstn_q;
   assign pll_if.sys_rstn_o  = sys_rstn_q;
   assign pll_if.state_o     = state_q;
   assign pll_if.retry_cnt_o = retry_cnt_q;
   assign pll_if.fail_o      = fail_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   logic [15:0] loss_cnt_q, loss_cnt_d;

   // Only rstn clears this count; a retry pulse leaves it alone.
   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (!pll_if.retry_i && state_q == c_st_run && !lock_s_q && loss_cnt_q != 16'hFFFF)
         loss_cnt_d = loss_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         loss_cnt_q <= '0;
      else
         loss_cnt_q <= loss_cnt_d;
   end

   assign pll_if.lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/red_pitaya_pll_rst_seq.md
Name: red_pitaya_pll_rst_seq

Overview:
- Reset/lock sequencer directly upstream and downstream of the board PLL.
- Drives the PLL's active-low reset, waits for and qualifies LOCKED, then releases the system reset for the clk_adc/clk_dac/clk_ser domains.
- Re-sequences on loss of lock, with bounded retries and a timeout.
- Runs on the free-running 125 MHz input clock that feeds the PLL, not on any PLL output.

Parameters:
- PLL_RST_CYC, 16, cycles pll_rstn_o is held low per attempt (minimum 1)
- LOCK_TMO_CYC, 65536, cycles to wait for synchronized lock before retrying
- LOCK_STB_CYC, 1024, consecutive locked cycles required before system reset release
- MAX_RETRY, 4, attempts (timeouts or lock losses) allowed before FAIL; 0 means unlimited
- CNT_W, 17, width of the shared cycle counter; must hold the largest *_CYC value

Ports:
- clk  input  1  free-running PLL reference clock, 125 MHz
- rstn  input  1  asynchronous active-low reset
- pll_locked_i  input  1  PLL LOCKED, asynchronous to clk
- retry_i  input  1  synchronous single-cycle pulse; restarts sequencing from any state
- pll_rstn_o  output  1  active-low reset to PLL
- sys_rstn_o  output  1  active-low reset for PLL-clocked logic
- state_o  output  3  current FSM state encoding
- retry_cnt_o  output  8  attempts consumed in the current sequence, saturating at 255
- fail_o  output  1  high while in FAIL

Behaviour:
- Reset is asynchronous and active-low. While rstn=0:
  - state is PLL_RST, counter is 0, retry_cnt_o is 0.
  - pll_rstn_o=0, sys_rstn_o=0, fail_o=0.
- pll_locked_i passes through a 2-FF synchronizer whose flops reset to 0. lock_s is the output of the 2nd flop. This adds 2 cycles of lock latency.
- All outputs are registered.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RST:
  - pll_rstn_o=0, sys_rstn_o=0.
  - Counter counts PLL_RST_CYC cycles, then the FSM goes to WAIT_LOCK with the counter cleared.
  - pll_rstn_o rises in the same cycle the state becomes WAIT_LOCK.
- WAIT_LOCK:
  - pll_rstn_o=1, sys_rstn_o=0.
  - lock_s=1 goes to STABLE with the counter cleared.
  - If the counter reaches LOCK_TMO_CYC-1 without lock, it is a timeout: retry_cnt_o increments, and the FSM goes to PLL_RST, or to FAIL if the new count equals MAX_RETRY (MAX_RETRY≠0).
- STABLE:
  - lock_s=0 returns to WAIT_LOCK with the counter cleared. No retry is consumed and the timeout restarts.
  - After LOCK_STB_CYC consecutive cycles with lock_s=1, the FSM goes to RUN.
- RUN:
  - sys_rstn_o=1 from the first cycle in RUN.
  - retry_cnt_o clears to 0 on entry.
  - lock_s=0 deasserts sys_rstn_o on the next clock edge, increments retry_cnt_o and goes to PLL_RST.
- FAIL:
  - pll_rstn_o=0 (PLL held in reset), sys_rstn_o=0, fail_o=1.
  - Exits only via rstn or retry_i.
- retry_i=1 in any state:
  - Next state is PLL_RST, counter cleared, retry_cnt_o cleared, sys_rstn_o=0 next cycle.
  - retry_i has priority over every other transition in the same cycle.
- Simultaneous events:
  - Timeout and lock_s rising in the same cycle: lock wins, next state is STABLE.
  - Counter reaching LOCK_STB_CYC-1 in the same cycle lock_s drops: drop wins, next state is WAIT_LOCK.
- Counter never wraps: it clears on every state change and its compare is ≥ the limit.
- retry_cnt_o saturates at 255.

Optional Feature:
- Macro PLL_RST_SEQ_LOSS_CNT_EN.
- When defined:
  - Adds output lock_loss_cnt_o [15:0], a count of RUN→PLL_RST transitions.
  - Saturates at 16'hFFFF.
  - Cleared only by rstn (not by retry_i).
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
All scenarios use PLL_RST_CYC=4, LOCK_TMO_CYC=32, LOCK_STB_CYC=8, MAX_RETRY=3.

1. Release rstn; assert pll_locked_i 10 cycles after pll_rstn_o rises and hold it -> pll_rstn_o low exactly 4 cycles; sys_rstn_o rises 2+8 cycles after lock rise (±1 for async sampling); retry_cnt_o=0.
2. Never assert lock -> three PLL_RST/WAIT_LOCK cycles of 4+32 cycles each; retry_cnt_o reaches 3; state_o=4; fail_o=1; pll_rstn_o=0 held.
3. In STABLE, drop lock at stable count 5 for 1 cycle, then hold it -> state returns to WAIT_LOCK, retry_cnt_o unchanged, a full 8-cycle qualification repeats, then RUN.
4. In RUN, drop lock -> sys_rstn_o=0 within 3 cycles of the pin falling; state_o=0; retry_cnt_o=1; lock_loss_cnt_o=1 when the macro is defined.
5. In FAIL, pulse retry_i for 1 cycle -> state_o=0, retry_cnt_o=0, fail_o=0 next cycle; then normal lock reaches RUN.
6. Assert rstn low mid-STABLE -> all outputs return to reset values immediately, without waiting for a clock edge.
